dsi_lanes_sequencer: RTL and testbench

DSI_LANES_SEQUENCER -- requirements
Module: dsi_lanes_sequencer

---
 rtl/dsi_pkg.sv | 35 +++
 rtl/dsi_seq_timer.sv | 36 +++
 rtl/dsi_lanes_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_dsi_lanes_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsi_pkg.sv
// Shared definitions for the DSI lane sequencer.
// Contents: the sequencer state encoding, counter width, default timing
// constants and the filler byte that is sent to the lanes on underflow.
package dsi_pkg;

    localparam int unsigned CNT_W          = 8;
    localparam int unsigned DEF_T_CLK_PRE  = 8;
    localparam int unsigned DEF_T_CLK_POST = 16;
    localparam int unsigned DEF_T_WDOG     = 255;

    localparam logic [7:0] FILLER_BYTE = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLK_START = 3'd1,
        ST_CLK_PRE   = 3'd2,
        ST_DL_START  = 3'd3,
        ST_STREAM    = 3'd4,
        ST_DL_FIN    = 3'd5,
        ST_CLK_POST  = 3'd6,
        ST_CLK_FIN   = 3'd7
    } seq_state_t;

    // States that wait on a lane acknowledge and are guarded by the watchdog.
    function automatic logic is_wdog_state(input seq_state_t s);
        return (s == ST_CLK_START) || (s == ST_DL_START) ||
               (s == ST_DL_FIN)    || (s == ST_CLK_FIN);
    endfunction

    // States that time a fixed clock-lane guard interval.
    function automatic logic is_phase_state(input seq_state_t s);
        return (s == ST_CLK_PRE) || (s == ST_CLK_POST);
    endfunction

endpackage

// File: rtl/dsi_seq_timer.sv
// Shared phase / watchdog counter for the DSI lane sequencer.
// Ports:
//   clk_sys, rst  - clock, asynchronous active-high reset
//   load          - clear the count to zero (wins over en)
//   en            - advance the count by one
//   count         - cycles spent in the current state (registered)
//   expiry_c      - count is on its LIMIT-th counted cycle
module dsi_seq_timer
    import dsi_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_T_WDOG
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             expiry_c
);

    localparam logic [CNT_W-1:0] LIMIT_LAST = CNT_W'(LIMIT - 1);

    // Count register: cleared on load, held when not enabled.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expiry_c = en & (count == LIMIT_LAST);

endmodule

// File: rtl/dsi_lanes_sequencer.sv
// DSI clock/data lane sequencer: brings the clock lane into HS, starts the
// data lanes, streams packet beats (one byte per lane), then winds the data
// and clock lanes down, with a watchdog on every lane acknowledge.
// Ports:
//   clk_sys, rst                 - clock, asynchronous active-high reset
//   pkt_valid/pkt_data/pkt_last  - beat source; pkt_ready consumes a beat
//   clk_start_rqst/clk_fin_rqst  - clock lane control, clk_active its status
//   dl_start_rqst/dl_fin_rqst    - control common to all data lanes
//   dl_data/dl_data_rqst         - per-lane byte and per-lane byte request
//   dl_active                    - per-lane HS status
//   busy                         - sequencer is not idle
//   err_underflow/err_timeout    - single-cycle error pulses
// Build option: DSI_CLK_CONTINUOUS_EN keeps the clock lane in HS between
// bursts (no CLK_POST / CLK_FIN, IDLE jumps to CLK_PRE when clk_active).
module dsi_lanes_sequencer
    import dsi_pkg::*;
#(
    parameter int unsigned LANES      = 4,
    parameter int unsigned T_CLK_PRE  = DEF_T_CLK_PRE,
    parameter int unsigned T_CLK_POST = DEF_T_CLK_POST,
    parameter int unsigned T_WDOG     = DEF_T_WDOG
) (
    input  logic               clk_sys,
    input  logic               rst,
    input  logic               pkt_valid,
    input  logic [8*LANES-1:0] pkt_data,
    input  logic               pkt_last,
    output logic               pkt_ready,
    output logic               clk_start_rqst,
    output logic               clk_fin_rqst,
    input  logic               clk_active,
    output logic               dl_start_rqst,
    output logic               dl_fin_rqst,
    output logic [8*LANES-1:0] dl_data,
    input  logic [LANES-1:0]   dl_data_rqst,
    input  logic [LANES-1:0]   dl_active,
    output logic               busy,
    output logic               err_underflow,
    output logic               err_timeout
);

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(T_CLK_PRE - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(T_CLK_POST - 1);

    seq_state_t       state;
    seq_state_t       state_nxt_c;
    logic             all_rqst_c;
    logic             any_rqst_c;
    logic             lanes_idle_c;
    logic             tmr_en_c;
    logic             tmr_load_c;
    logic             wdog_exp_c;
    logic             phase_done_c;
    logic             timeout_c;
    logic             underflow_c;
    logic [CNT_W-1:0] tmr_count;

    assign all_rqst_c   = &dl_data_rqst;
    assign any_rqst_c   = |dl_data_rqst;
    assign lanes_idle_c = ~|dl_active;

    // A beat is consumed only when every lane asks for a byte together.
    assign pkt_ready = (state == ST_STREAM) & all_rqst_c & pkt_valid;

    // Any lane request that cannot be served with a whole beat is an underflow.
    assign underflow_c = (state == ST_STREAM) & any_rqst_c & ~pkt_ready;

    assign tmr_en_c   = is_wdog_state(state) | is_phase_state(state);
    assign tmr_load_c = (state_nxt_c != state);

    assign phase_done_c = ((state == ST_CLK_PRE)  && (tmr_count == PRE_LAST)) ||
                          ((state == ST_CLK_POST) && (tmr_count == POST_LAST));

    dsi_seq_timer #(
        .LIMIT (T_WDOG)
    ) u_timer (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .load     (tmr_load_c),
        .en       (tmr_en_c),
        .count    (tmr_count),
        .expiry_c (wdog_exp_c)
    );

    // Next-state decision; normal progress has priority over a watchdog expiry.
    always_comb begin
        state_nxt_c = state;
        timeout_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pkt_valid) begin
`ifdef DSI_CLK_CONTINUOUS_EN
                    state_nxt_c = clk_active ? ST_CLK_PRE : ST_CLK_START;
`else
                    state_nxt_c = ST_CLK_START;
`endif
                end
            end
            ST_CLK_START: begin
                if (clk_active) begin
                    state_nxt_c = ST_CLK_PRE;
                end else if (wdog_exp_c) begin
                    state_nxt_c = ST_IDLE;
                    timeout_c   = 1'b1;
                end
            end
            ST_CLK_PRE: begin
                if (phase_done_c) begin
                    state_nxt_c = ST_DL_START;
                end
            end
            ST_DL_START: begin
                if (all_rqst_c) begin
                    state_nxt_c = ST_STREAM;
                end else if (wdog_exp_c) begin
                    state_nxt_c = ST_IDLE;
                    timeout_c   = 1'b1;
                end
            end
            ST_STREAM: begin
                if (pkt_ready && pkt_last) begin
                    state_nxt_c = ST_DL_FIN;
                end
            end
            ST_DL_FIN: begin
                if (lanes_idle_c) begin
`ifdef DSI_CLK_CONTINUOUS_EN
                    state_nxt_c = ST_IDLE;
`else
                    state_nxt_c = ST_CLK_POST;
`endif
                end else if (wdog_exp_c) begin
                    state_nxt_c = ST_IDLE;
                    timeout_c   = 1'b1;
                end
            end
            ST_CLK_POST: begin
                if (phase_done_c) begin
                    state_nxt_c = ST_CLK_FIN;
                end
            end
            ST_CLK_FIN: begin
                if (!clk_active) begin
                    state_nxt_c = ST_IDLE;
                end else if (wdog_exp_c) begin
                    state_nxt_c = ST_IDLE;
                    timeout_c   = 1'b1;
                end
            end
            default: begin
                state_nxt_c = ST_IDLE;
            end
        endcase
    end

    // State register; request outputs are decoded from the next state so
    // they line up exactly with the registered state.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            clk_start_rqst <= 1'b0;
            clk_fin_rqst   <= 1'b0;
            dl_start_rqst  <= 1'b0;
            dl_fin_rqst    <= 1'b0;
            busy           <= 1'b0;
            err_underflow  <= 1'b0;
            err_timeout    <= 1'b0;
            dl_data        <= '0;
        end else begin
            state          <= state_nxt_c;
            clk_start_rqst <= (state_nxt_c == ST_CLK_START);
            clk_fin_rqst   <= (state_nxt_c == ST_CLK_FIN);
            dl_start_rqst  <= (state_nxt_c == ST_DL_START);
            dl_fin_rqst    <= (state_nxt_c == ST_DL_FIN);
            busy           <= (state_nxt_c != ST_IDLE);
            err_underflow  <= underflow_c;
            err_timeout    <= timeout_c;
            if (pkt_ready) begin
                dl_data <= pkt_data;
            end else if (underflow_c) begin
                dl_data <= {LANES{FILLER_BYTE}};
            end
        end
    end

endmodule

// File: tb/tb_dsi_lanes_sequencer.sv
`timescale 1ns/1ps
module tb_dsi_lanes_sequencer;

    localparam int unsigned T_PRE  = 8;
    localparam int unsigned T_POST = 16;
    localparam int unsigned T_WD   = 255;
    localparam int NB = 6;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;
    logic rst;

    // 4-lane instance
    logic        pkt_valid, pkt_last, pkt_ready;
    logic [31:0] pkt_data, dl_data;
    logic        clk_start_rqst, clk_fin_rqst, clk_active;
    logic        dl_start_rqst, dl_fin_rqst, busy, err_underflow, err_timeout;
    logic [3:0]  dl_data_rqst, dl_active;

    // 1-lane instance
    logic        s_pkt_valid, s_pkt_last, s_pkt_ready;
    logic [7:0]  s_pkt_data, s_dl_data;
    logic        s_clk_start_rqst, s_clk_fin_rqst, s_clk_active;
    logic        s_dl_start_rqst, s_dl_fin_rqst, s_busy, s_err_underflow, s_err_timeout;
    logic [0:0]  s_dl_data_rqst, s_dl_active;

    dsi_lanes_sequencer #(.LANES(4), .T_CLK_PRE(T_PRE), .T_CLK_POST(T_POST), .T_WDOG(T_WD)) dut4 (
        .clk_sys(clk_sys), .rst(rst), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
        .pkt_last(pkt_last), .pkt_ready(pkt_ready), .clk_start_rqst(clk_start_rqst),
        .clk_fin_rqst(clk_fin_rqst), .clk_active(clk_active), .dl_start_rqst(dl_start_rqst),
        .dl_fin_rqst(dl_fin_rqst), .dl_data(dl_data), .dl_data_rqst(dl_data_rqst),
        .dl_active(dl_active), .busy(busy), .err_underflow(err_underflow),
        .err_timeout(err_timeout));

    dsi_lanes_sequencer #(.LANES(1), .T_CLK_PRE(T_PRE), .T_CLK_POST(T_POST), .T_WDOG(T_WD)) dut1 (
        .clk_sys(clk_sys), .rst(rst), .pkt_valid(s_pkt_valid), .pkt_data(s_pkt_data),
        .pkt_last(s_pkt_last), .pkt_ready(s_pkt_ready), .clk_start_rqst(s_clk_start_rqst),
        .clk_fin_rqst(s_clk_fin_rqst), .clk_active(s_clk_active), .dl_start_rqst(s_dl_start_rqst),
        .dl_fin_rqst(s_dl_fin_rqst), .dl_data(s_dl_data), .dl_data_rqst(s_dl_data_rqst),
        .dl_active(s_dl_active), .busy(s_busy), .err_underflow(s_err_underflow),
        .err_timeout(s_err_timeout));

    int checks = 0;
    int errors = 0;

    // Reference state kept by the bench: last word the lanes should hold,
    // and how many clock-lane fin requests the bursts should have produced.
    logic [31:0] model_dl = '0;
    int          exp_fins = 0;
    logic [31:0] early_word;
    logic        early_last;

    logic [31:0] bursts [NB][6];
    int          lens [NB];

    typedef struct {
        logic [3:0]  rqst;
        logic        valid;
        logic        last;
        logic [31:0] data;
        logic        exp_ready;
        logic        exp_uf;
        logic [31:0] exp_dl;
    } vec_t;
    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Count rising edges of clk_fin_rqst over the whole run.
    int   fin_edges = 0;
    logic fin_prev  = 1'b0;
    always @(negedge clk_sys) begin
        if (clk_fin_rqst && !fin_prev) fin_edges++;
        fin_prev = clk_fin_rqst;
    end

    // From a pending pkt_valid in IDLE up to the first STREAM cycle.
    task automatic bring_up();
        int k;
        for (k = 0; k < 10 && !busy; k++) @(negedge clk_sys);
        check("busy_rise", busy, 1);
        if (!clk_active) begin
            check("clk_start_rqst", clk_start_rqst, 1);
            repeat ($urandom_range(0, 3)) @(negedge clk_sys);
            clk_active = 1'b1;
            @(negedge clk_sys);
            check("clk_start_drop", clk_start_rqst, 0);
        end
        for (k = 0; k < 300 && !dl_start_rqst; k++) @(negedge clk_sys);
        check("t_clk_pre", k, T_PRE);
        check("dl_start_rqst", dl_start_rqst, 1);
        repeat ($urandom_range(0, 2)) @(negedge clk_sys);
        dl_active = 4'hF;
        repeat ($urandom_range(0, 2)) @(negedge clk_sys);
        dl_data_rqst = 4'hF;
        @(negedge clk_sys);
        check("dl_start_drop", dl_start_rqst, 0);
    endtask

    // From DL_FIN back to IDLE; optionally offers the next burst during CLK_POST.
    task automatic wind_down(input logic early);
        int k;
        check("dl_fin_rqst", dl_fin_rqst, 1);
        pkt_valid = 1'b0; pkt_last = 1'b0; dl_data_rqst = 4'h0;
        repeat ($urandom_range(0, 2)) @(negedge clk_sys);
        check("dl_fin_hold", dl_fin_rqst, 1);
        dl_active = 4'h0;
        @(negedge clk_sys);
        check("dl_fin_drop", dl_fin_rqst, 0);
`ifdef DSI_CLK_CONTINUOUS_EN
        check("idle_after_dl_fin", busy, 0);
        if (early) check("no_early_in_continuous", 0, 1);
`else
        for (k = 0; k < 300 && !clk_fin_rqst; k++) begin
            if (early && k == 3) begin
                pkt_valid = 1'b1; pkt_data = early_word; pkt_last = early_last;
            end
            @(negedge clk_sys);
        end
        check("t_clk_post", k, T_POST);
        check("clk_fin_rqst", clk_fin_rqst, 1);
        exp_fins++;
        repeat ($urandom_range(0, 2)) @(negedge clk_sys);
        check("busy_in_clk_fin", busy, 1);
        clk_active = 1'b0;
        @(negedge clk_sys);
        check("idle_after_clk_fin", busy, 0);
        check("clk_fin_drop", clk_fin_rqst, 0);
`endif
    endtask

    // Randomised lane requests and source gaps against the streaming rules.
    task automatic stream_random(input int r);
        int          idx;
        logic [3:0]  rq;
        logic        v, exp_rdy, exp_uf;
        idx = 0;
        for (int c = 0; c < 400 && idx < lens[r]; c++) begin
            if (c > 40) begin
                rq = 4'hF; v = 1'b1;
            end else begin
                case ($urandom_range(0, 9))
                    0:       rq = 4'h0;
                    1:       rq = 4'($urandom);
                    default: rq = 4'hF;
                endcase
                v = ($urandom_range(0, 4) != 0);
            end
            dl_data_rqst = rq;
            pkt_valid    = v;
            pkt_data     = v ? bursts[r][idx] : $urandom;
            pkt_last     = v && (idx == lens[r] - 1);
            exp_rdy      = (rq == 4'hF) && v;
            #1 check("pkt_ready", pkt_ready, exp_rdy);
            if (exp_rdy) begin
                model_dl = bursts[r][idx]; idx++; exp_uf = 1'b0;
            end else if (rq != 4'h0) begin
                model_dl = 32'h0; exp_uf = 1'b1;
            end else begin
                exp_uf = 1'b0;
            end
            @(negedge clk_sys);
            check("dl_data", dl_data, model_dl);
            check("err_underflow", err_underflow, exp_uf);
        end
        check("burst_done", idx, lens[r]);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global time limit");
    end

    initial begin
        int   k;
        int   cnt;
        logic early;

        tbl[0] = '{4'hF, 1'b1, 1'b0, 32'h03020100, 1'b1, 1'b0, 32'h03020100};
        tbl[1] = '{4'hF, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 32'h00000000};
        tbl[2] = '{4'h0, 1'b1, 1'b0, 32'h07060504, 1'b0, 1'b0, 32'h00000000};
        tbl[3] = '{4'h5, 1'b1, 1'b0, 32'h07060504, 1'b0, 1'b1, 32'h00000000};
        tbl[4] = '{4'hF, 1'b1, 1'b0, 32'h07060504, 1'b1, 1'b0, 32'h07060504};
        tbl[5] = '{4'h0, 1'b0, 1'b0, 32'h07060504, 1'b0, 1'b0, 32'h07060504};
        tbl[6] = '{4'hF, 1'b1, 1'b1, 32'h0B0A0908, 1'b1, 1'b0, 32'h0B0A0908};

        for (int r = 0; r < NB; r++) begin
            lens[r] = (r == 0) ? 1 : int'($urandom_range(1, 5));
            for (int b = 0; b < 6; b++) bursts[r][b] = $urandom;
        end

        rst = 1'b1;
        pkt_valid = 0; pkt_last = 0; pkt_data = '0; clk_active = 0;
        dl_data_rqst = '0; dl_active = '0;
        s_pkt_valid = 0; s_pkt_last = 0; s_pkt_data = '0; s_clk_active = 0;
        s_dl_data_rqst = '0; s_dl_active = '0;
        repeat (3) @(negedge clk_sys);
        check("rst_busy", busy, 0);
        check("rst_dl_data", dl_data, 0);
        check("rst_clk_start", clk_start_rqst, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_s_busy", s_busy, 0);
        check("rst_s_dl_data", s_dl_data, 0);
        rst = 1'b0;
        @(negedge clk_sys);

        // Three-beat burst with gaps and lane mismatches, table driven.
        pkt_valid = 1'b1; pkt_data = 32'h03020100; pkt_last = 1'b0;
        bring_up();
        for (int i = 0; i < 7; i++) begin
            dl_data_rqst = tbl[i].rqst;
            pkt_valid    = tbl[i].valid;
            pkt_last     = tbl[i].last;
            pkt_data     = tbl[i].data;
            #1 check($sformatf("tbl%0d_ready", i), pkt_ready, tbl[i].exp_ready);
            @(negedge clk_sys);
            check($sformatf("tbl%0d_dl_data", i), dl_data, tbl[i].exp_dl);
            check($sformatf("tbl%0d_underflow", i), err_underflow, tbl[i].exp_uf);
        end
        model_dl = 32'h0B0A0908;
        wind_down(1'b0);

        // Clock lane never acknowledges: watchdog expiry from CLK_START.
        clk_active = 1'b0;
        pkt_valid = 1'b1; pkt_data = 32'h11223344; pkt_last = 1'b0;
        for (k = 0; k < 10 && !busy; k++) @(negedge clk_sys);
        cnt = 0;
        while (clk_start_rqst && cnt < 400) begin
            cnt++;
            @(negedge clk_sys);
        end
        check("wdog_cycles", cnt, T_WD);
        check("err_timeout", err_timeout, 1);
        check("busy_after_timeout", busy, 0);
        pkt_valid = 1'b0;
        @(negedge clk_sys);
        check("err_timeout_pulse", err_timeout, 0);
        check("idle_after_timeout", busy, 0);

        // Reset in STREAM clears everything at once.
        pkt_valid = 1'b1; pkt_data = 32'hDEADBEEF; pkt_last = 1'b0;
        bring_up();
        @(negedge clk_sys);
        check("dl_data_before_rst", dl_data, 32'hDEADBEEF);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_dl_data", dl_data, 0);
        check("rst_mid_pkt_ready", pkt_ready, 0);
        check("rst_mid_reqs", {clk_start_rqst, clk_fin_rqst, dl_start_rqst, dl_fin_rqst}, 0);
        check("rst_mid_errs", {err_underflow, err_timeout}, 0);
        pkt_valid = 0; clk_active = 0; dl_active = '0; dl_data_rqst = '0;
        model_dl = '0;
        @(negedge clk_sys);
        rst = 1'b0;
        @(negedge clk_sys);

        // Random bursts, the first a single beat.
        early = 1'b0;
        for (int r = 0; r < NB; r++) begin
            if (!early) begin
                pkt_valid = 1'b1; pkt_data = bursts[r][0]; pkt_last = (lens[r] == 1);
            end
            bring_up();
            stream_random(r);
`ifdef DSI_CLK_CONTINUOUS_EN
            early = 1'b0;
`else
            early = (r < NB - 1) && ($urandom_range(0, 1) == 1);
`endif
            if (early) begin
                early_word = bursts[r+1][0];
                early_last = (lens[r+1] == 1);
            end
            wind_down(early);
        end
        check("clk_fin_count", fin_edges, exp_fins);

        // Single lane, single beat.
        s_pkt_valid = 1'b1; s_pkt_data = 8'hA5; s_pkt_last = 1'b1;
        for (k = 0; k < 10 && !s_clk_start_rqst; k++) @(negedge clk_sys);
        check("s_clk_start", s_clk_start_rqst, 1);
        s_clk_active = 1'b1;
        for (k = 0; k < 40 && !s_dl_start_rqst; k++) @(negedge clk_sys);
        check("s_dl_start", s_dl_start_rqst, 1);
        s_dl_active = 1'b1; s_dl_data_rqst = 1'b1;
        @(negedge clk_sys);
        #1 check("s_pkt_ready", s_pkt_ready, 1);
        @(negedge clk_sys);
        check("s_dl_data", s_dl_data, 8'hA5);
        check("s_dl_fin", s_dl_fin_rqst, 1);
        s_pkt_valid = 0; s_pkt_last = 0; s_dl_data_rqst = 0; s_dl_active = 0;
`ifdef DSI_CLK_CONTINUOUS_EN
        @(negedge clk_sys);
        check("s_idle", s_busy, 0);
`else
        for (k = 0; k < 40 && !s_clk_fin_rqst; k++) @(negedge clk_sys);
        check("s_clk_fin", s_clk_fin_rqst, 1);
        s_clk_active = 1'b0;
        @(negedge clk_sys);
        check("s_idle", s_busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
